pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the RISC-V in-order pipeline. It replaces the fixed rd-address comparison pass-through currently wired into decode.
- Keeps a shift-register scoreboard of in-flight register writers past ID. Outputs per-operand forwarding selects, stall and flush controls, and a stall counter.
- Sits beside instruction_decode. Drives pc_load, if_id_load and the pipeline-register flush inputs.

Parameters:
- PIPE_DEPTH, 3: number of tracked stages after ID (1=EX, 2=MEM, 3=WB).
- ALU_READY, 1: stage index from which a non-load result can be forwarded.
- LOAD_READY, 2: stage index from which a load result can be forwarded. Must satisfy ALU_READY <= LOAD_READY <= PIPE_DEPTH.
- FLUSH_CYCLES, 1: number of cycles the flush stays asserted after a taken branch.
- CNT_W, 32: width of the stall counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source register 1
- id_rs2  in  5  source register 2
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd  in  5  destination register
- id_reg_write  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- branch_taken_ex  in  1  taken branch/jump resolved in EX this cycle
- mem_busy  in  1  data memory not ready; freezes the whole pipeline
- fwd_a_sel  out  SELW  source for rs1: 0 = register file, k = stage k. SELW = $clog2(PIPE_DEPTH+1).
- fwd_b_sel  out  SELW  same encoding, for rs2
- pc_load  out  1  PC update enable
- if_id_load  out  1  IF/ID register enable
- if_id_flush  out  1  clear IF/ID
- id_ex_flush  out  1  insert bubble into ID/EX
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard entries are sb[1..PIPE_DEPTH], each holding {valid, rd, is_load}.
  - An entry is created only if id_valid & id_reg_write & id_rd != 0.
  - Writes to x0 are never tracked.
- Match for an operand: uses_rsX & rsX != 0 & sb[k].valid & sb[k].rd == rsX.
  - Only the youngest match (lowest k) counts.
  - Ready if k >= (is_load ? LOAD_READY : ALU_READY).
- fwd_X_sel (combinational):
  - k when the youngest match is ready.
  - 0 when there is no match.
  - Don't-care (drive 0) while stalled.
- hazard = id_valid & (youngest match on rs1 or rs2 is not ready).
- Control priority is reset > mem_busy > flush > hazard > normal.
- mem_busy (combinational):
  - pc_load = if_id_load = 0, both flush outputs = 0.
  - Scoreboard holds its contents; stall_count does not change.
- Flush:
  - Asserted when branch_taken_ex = 1, or when flush_cnt != 0.
  - if_id_flush = id_ex_flush = 1, pc_load = 1 (branch target), if_id_load = 1.
  - The next sb[1] is a bubble.
- flush_cnt:
  - Loads FLUSH_CYCLES-1 on branch_taken_ex.
  - Otherwise decrements when nonzero and mem_busy = 0.
  - A new branch_taken_ex while it is counting reloads it.
- Hazard:
  - pc_load = if_id_load = 0, id_ex_flush = 1, if_id_flush = 0.
  - Next sb[1] is a bubble.
  - stall_count increments, saturating at all-ones.
- Normal:
  - pc_load = if_id_load = 1, both flushes = 0.
  - Next sb[1] takes the ID instruction.
- Shift: whenever mem_busy = 0, sb[k+1] <= sb[k] for k < PIPE_DEPTH, and sb[PIPE_DEPTH] is discarded.
- Register file is write-then-read. A producer that leaves the scoreboard needs no forwarding.
- Reset (asynchronous, at any time):
  - All sb valid bits = 0, flush_cnt = 0, stall_count = 0.
  - Outputs during reset: pc_load = if_id_load = 1, flushes = 0, fwd selects = 0.
  - Reset in the middle of a stall or flush drops all pending state immediately.
- Latency:
  - Every control output is combinational from inputs and current state.
  - State updates on the rising edge.
  - With default parameters a load-use pair costs exactly 1 stall cycle.

Test Plan:
- ALU back-to-back: add x5 then a consumer with rs1=5 in ID. Required: fwd_a_sel=1, pc_load=1, stall_count unchanged.
- Load-use: lw x6, then a consumer with rs2=6. Required: cycle 1 pc_load=0, id_ex_flush=1, stall_count=1. Cycle 2 fwd_b_sel=2, pc_load=1.
- Youngest priority and x0:
  - Writers of x7 at stages 1 and 2, consumer rs1=7: fwd_a_sel=1.
  - Consumer with rs1=0 and an addi x0 in flight: fwd_a_sel=0, no stall.
- Branch flush: branch_taken_ex pulse with FLUSH_CYCLES=2. Required: if_id_flush=id_ex_flush=1 for 2 cycles, and sb[1] is invalid after each.
- mem_busy held 3 cycles during a load-use hazard. Required: pc_load=0, scoreboard frozen, stall_count unchanged. After release there is 1 stall, then the consumer proceeds.
- Reset mid-stall, asserted asynchronously between edges. Required: outputs return to reset values immediately. After release the same consumer issues with fwd selects = 0 and no stall.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the in-order RISC-V pipeline.
// A shift-register scoreboard tracks in-flight writers past ID and drives forwarding, stall and flush controls.
module pipeline_hazard_unit #(
    parameter int PIPE_DEPTH   = 3,
    parameter int ALU_READY    = 1,
    parameter int LOAD_READY   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32,
    localparam int SELW        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             branch_taken_ex,
    input  logic             mem_busy,
    output logic [SELW-1:0]  fwd_a_sel,
    output logic [SELW-1:0]  fwd_b_sel,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic            hit;
        logic            ready;
        logic [SELW-1:0] stage;
    } match_t;

    logic       sb_valid [1:PIPE_DEPTH];
    logic [4:0] sb_rd    [1:PIPE_DEPTH];
    logic       sb_load  [1:PIPE_DEPTH];

    logic [FCW-1:0] flush_cnt;
    logic           flush_act;
    logic           hazard;
    logic           stall_inc;
    logic           nxt_valid;
    match_t         match_a;
    match_t         match_b;

    // Scan oldest to youngest so the lowest stage index wins.
    function automatic match_t find_match(input logic uses, input logic [4:0] rs);
        match_t m;
        m = '0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (uses && rs != 5'd0 && sb_valid[k] && sb_rd[k] == rs) begin
                m.hit   = 1'b1;
                m.stage = SELW'(k);
                m.ready = (k >= (sb_load[k] ? LOAD_READY : ALU_READY));
            end
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb match_a = find_match(id_uses_rs1, id_rs1);
    always_comb match_b = find_match(id_uses_rs2, id_rs2);

    assign hazard    = id_valid & ((match_a.hit & ~match_a.ready) |
                                   (match_b.hit & ~match_b.ready));
    assign flush_act = branch_taken_ex | (flush_cnt != '0);

    always_comb begin
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        fwd_a_sel   = '0;
        fwd_b_sel   = '0;
        stall_inc   = 1'b0;
        nxt_valid   = 1'b0;
        if (reset) begin
            pc_load    = 1'b1;
            if_id_load = 1'b1;
        end else if (mem_busy) begin
            pc_load    = 1'b0;
            if_id_load = 1'b0;
        end else if (flush_act) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hazard) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            nxt_valid = id_valid & id_reg_write & (id_rd != 5'd0);
        end
        if (!reset && !hazard) begin
            if (match_a.hit && match_a.ready) fwd_a_sel = match_a.stage;
            if (match_b.hit && match_b.ready) fwd_b_sel = match_b.stage;
        end
    end

    // Control state: scoreboard valid bits, flush counter, stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) sb_valid[k] <= 1'b0;
            flush_cnt   <= '0;
            stall_count <= '0;
        end else begin
            if (branch_taken_ex) begin
                flush_cnt <= FCW'(FLUSH_CYCLES - 1);
            end else if (flush_cnt != '0 && !mem_busy) begin
                flush_cnt <= flush_cnt - FCW'(1);
            end
            if (!mem_busy) begin
                sb_valid[1] <= nxt_valid;
                for (int k = 2; k <= PIPE_DEPTH; k++) sb_valid[k] <= sb_valid[k-1];
                if (stall_inc) stall_count <= sat_inc(stall_count);
            end
        end
    end

    // Scoreboard payload only matters where the valid bit is set.
    always_ff @(posedge clock) begin
        if (!mem_busy) begin
            sb_rd[1]   <= id_rd;
            sb_load[1] <= id_is_load;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                sb_rd[k]   <= sb_rd[k-1];
                sb_load[k] <= sb_load[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed test-plan steps then random traffic against a reference model.
module tb_pipeline_hazard_unit;

    localparam int PD    = 3;
    localparam int ALU_R = 1;
    localparam int LD_R  = 2;
    localparam int FC    = 2;
    localparam int CW    = 32;
    localparam int SW    = $clog2(PD + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          branch_taken_ex, mem_busy;
    logic [SW-1:0] fwd_a_sel, fwd_b_sel;
    logic          pc_load, if_id_load, if_id_flush, id_ex_flush;
    logic [CW-1:0] stall_count;

    pipeline_hazard_unit #(
        .PIPE_DEPTH(PD), .ALU_READY(ALU_R), .LOAD_READY(LD_R),
        .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .pc_load(pc_load), .if_id_load(if_id_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: list of in-flight writers, index 1 = youngest.
    logic          m_v  [1:PD];
    logic [4:0]    m_rd [1:PD];
    logic          m_ld [1:PD];
    int            m_fcnt;
    logic [CW-1:0] m_stall;
    logic          e_pc, e_ifl, e_iff, e_idf, e_haz, e_flush;
    int            e_fa, e_fb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 1; k <= PD; k++) m_v[k] = 1'b0;
        m_fcnt  = 0;
        m_stall = '0;
    endtask

    function automatic int youngest(input logic uses, input logic [4:0] rs, output bit rdy);
        rdy = 1'b1;
        if (!uses || rs == 5'd0) return 0;
        for (int k = 1; k <= PD; k++) begin
            if (m_v[k] && m_rd[k] == rs) begin
                rdy = (k >= (m_ld[k] ? LD_R : ALU_R));
                return k;
            end
        end
        return 0;
    endfunction

    task automatic model_eval();
        bit ra, rb;
        int ka, kb;
        ka = youngest(id_uses_rs1, id_rs1, ra);
        kb = youngest(id_uses_rs2, id_rs2, rb);
        e_haz   = id_valid && ((ka != 0 && !ra) || (kb != 0 && !rb));
        e_flush = branch_taken_ex || m_fcnt != 0;
        if (reset)          {e_pc, e_ifl, e_iff, e_idf} = 4'b1100;
        else if (mem_busy)  {e_pc, e_ifl, e_iff, e_idf} = 4'b0000;
        else if (e_flush)   {e_pc, e_ifl, e_iff, e_idf} = 4'b1111;
        else if (e_haz)     {e_pc, e_ifl, e_iff, e_idf} = 4'b0001;
        else                {e_pc, e_ifl, e_iff, e_idf} = 4'b1100;
        e_fa = (!reset && !e_haz && ra) ? ka : 0;
        e_fb = (!reset && !e_haz && rb) ? kb : 0;
    endtask

    task automatic model_tick();
        bit fl, hz;
        if (reset) begin
            model_clear();
            return;
        end
        fl = e_flush;
        hz = e_haz;
        if (branch_taken_ex) m_fcnt = FC - 1;
        else if (m_fcnt != 0 && !mem_busy) m_fcnt--;
        if (!mem_busy) begin
            if (!fl && hz && m_stall != '1) m_stall++;
            for (int k = PD; k >= 2; k--) begin
                m_v[k]  = m_v[k-1];
                m_rd[k] = m_rd[k-1];
                m_ld[k] = m_ld[k-1];
            end
            m_v[1]  = !fl && !hz && id_valid && id_reg_write && id_rd != 5'd0;
            m_rd[1] = id_rd;
            m_ld[1] = id_is_load;
        end
    endtask

    task automatic check_model();
        if (reset) model_clear();
        model_eval();
        chk("pc_load", pc_load, e_pc);
        chk("if_id_load", if_id_load, e_ifl);
        chk("if_id_flush", if_id_flush, e_iff);
        chk("id_ex_flush", id_ex_flush, e_idf);
        chk("stall_count", stall_count, m_stall);
        if (!mem_busy || reset) begin
            chk("fwd_a_sel", fwd_a_sel, e_fa);
            chk("fwd_b_sel", fwd_b_sel, e_fb);
        end
    endtask

    // Called just after a falling edge with inputs applied.
    task automatic step();
        #1;
        check_model();
        @(posedge clock);
        model_tick();
        @(negedge clock);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic ld);
        id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_is_load = ld;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [CW-1:0] snap;

    initial begin
        reset = 1'b1; branch_taken_ex = 1'b0; mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        @(negedge clock);
        #1;
        chk("rst_pc_load", pc_load, 1);
        chk("rst_stall", stall_count, 0);
        chk("rst_fwd_a", fwd_a_sel, 0);
        step();
        reset = 1'b0;
        idle(1);

        // ALU back-to-back
        set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        #1;
        chk("alu_fwd_a", fwd_a_sel, 1);
        chk("alu_pc_load", pc_load, 1);
        chk("alu_stall", stall_count, 0);
        step(); idle(3);

        // Load-use
        set_id(1, 0, 0, 0, 0, 6, 1, 1); step();
        set_id(1, 0, 0, 6, 1, 0, 0, 0);
        #1;
        chk("lu_c1_pc_load", pc_load, 0);
        chk("lu_c1_idex_flush", id_ex_flush, 1);
        step();
        #1;
        chk("lu_c1_stall", stall_count, 1);
        chk("lu_c2_fwd_b", fwd_b_sel, 2);
        chk("lu_c2_pc_load", pc_load, 1);
        step(); idle(3);

        // Youngest priority and x0
        set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
        set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
        set_id(1, 7, 1, 0, 0, 0, 0, 0);
        #1; chk("young_fwd_a", fwd_a_sel, 1);
        step();
        set_id(1, 0, 0, 0, 0, 0, 1, 0); step();
        set_id(1, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("x0_fwd_a", fwd_a_sel, 0);
        chk("x0_pc_load", pc_load, 1);
        step(); idle(3);

        // Branch flush, two cycles
        branch_taken_ex = 1'b1;
        set_id(1, 0, 0, 0, 0, 9, 1, 0);
        #1;
        chk("br_c1_ifid_flush", if_id_flush, 1);
        chk("br_c1_idex_flush", id_ex_flush, 1);
        step();
        branch_taken_ex = 1'b0;
        set_id(1, 0, 0, 0, 0, 10, 1, 0);
        #1;
        chk("br_c2_ifid_flush", if_id_flush, 1);
        chk("br_c2_idex_flush", id_ex_flush, 1);
        step();
        set_id(1, 9, 1, 10, 1, 0, 0, 0);
        #1;
        chk("br_c3_ifid_flush", if_id_flush, 0);
        chk("br_bubble_fwd_a", fwd_a_sel, 0);
        chk("br_bubble_fwd_b", fwd_b_sel, 0);
        chk("br_c3_pc_load", pc_load, 1);
        step(); idle(3);

        // mem_busy during a load-use hazard
        set_id(1, 0, 0, 0, 0, 6, 1, 1); step();
        set_id(1, 0, 0, 6, 1, 0, 0, 0);
        mem_busy = 1'b1;
        snap = m_stall;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mb_pc_load", pc_load, 0);
            chk("mb_idex_flush", id_ex_flush, 0);
            chk("mb_stall", stall_count, snap);
            step();
        end
        mem_busy = 1'b0;
        #1;
        chk("mb_rel_pc_load", pc_load, 0);
        chk("mb_rel_idex_flush", id_ex_flush, 1);
        step();
        #1;
        chk("mb_rel_stall", stall_count, snap + 1);
        chk("mb_rel_fwd_b", fwd_b_sel, 2);
        chk("mb_rel_pc_load", pc_load, 1);
        step(); idle(3);

        // Reset asserted between edges during a stall
        set_id(1, 0, 0, 0, 0, 6, 1, 1); step();
        set_id(1, 0, 0, 6, 1, 0, 0, 0);
        #1; chk("rs_pre_pc_load", pc_load, 0);
        #2; reset = 1'b1;
        #1;
        chk("rs_async_pc_load", pc_load, 1);
        chk("rs_async_idex_flush", id_ex_flush, 0);
        chk("rs_async_fwd_b", fwd_b_sel, 0);
        chk("rs_async_stall", stall_count, 0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rs_after_fwd_b", fwd_b_sel, 0);
        chk("rs_after_pc_load", pc_load, 1);
        step(); idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 99) < 2);
            mem_busy        = ($urandom_range(0, 99) < 20);
            branch_taken_ex = ($urandom_range(0, 99) < 8);
            set_id($urandom_range(0, 99) < 85,
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 2) == 0));
            step();
        end
        reset = 1'b0; mem_busy = 1'b0; branch_taken_ex = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
